jt10_adpcm_rom: RTL



---
 rtl/jt10_adpcm_rom_pkg.sv | 24 ++
 rtl/jt10_adpcm_rom_ch.sv | 57 +++++
 rtl/jt10_adpcm_rom.sv | 138 +++++++++++++
 3 files changed

// File: rtl/jt10_adpcm_rom_pkg.sv
// Shared definitions for the YM2610 ADPCM ROM responder.
// Contents: FSM state encoding, channel id constants, default region offsets
// and a helper that forms the 25-bit external byte address of a fetch.
package jt10_adpcm_rom_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  localparam logic CH_A = 1'b0;
  localparam logic CH_B = 1'b1;

  localparam logic [24:0] ADPCMA_OFFSET_DEF = 25'h000_0000;
  localparam logic [24:0] ADPCMB_OFFSET_DEF = 25'h100_0000;

  // Raw 24-bit channel address plus region base; the carry out of bit 24
  // is dropped so the sum wraps silently within the 32 MB space.
  function automatic logic [24:0] full_addr(input logic [23:0] raw,
                                            input logic [24:0] offset);
    return {1'b0, raw} + offset;
  endfunction

endpackage

// File: rtl/jt10_adpcm_rom_ch.sv
// Per-channel fetch bookkeeping for the ADPCM ROM responder.
// Holds the raw address of the last completed fetch (tag), whether that tag
// is meaningful, and the byte returned by that fetch.
// Ports:
//   clk, rst      - system clock, synchronous active-high reset
//   raw_addr      - 24-bit address currently driven by the core
//   roe_n         - core output enable, active low
//   wr_en         - completion of a fetch for this channel
//   wr_tag        - address that fetch was issued with
//   wr_data       - byte returned by memory
//   pending       - channel needs a fetch
//   data          - last byte fetched (registered)
module jt10_adpcm_rom_ch (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] raw_addr,
  input  logic        roe_n,
  input  logic        wr_en,
  input  logic [23:0] wr_tag,
  input  logic [7:0]  wr_data,
  output logic        pending,
  output logic [7:0]  data
);

  logic [23:0] tag_q, tag_d;
  logic        tag_valid_q, tag_valid_d;
  logic [7:0]  data_q, data_d;

  always_comb begin
    tag_d       = tag_q;
    tag_valid_d = tag_valid_q;
    data_d      = data_q;
    if (wr_en) begin
      tag_d       = wr_tag;
      tag_valid_d = 1'b1;
      data_d      = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q       <= 24'h0;
      tag_valid_q <= 1'b0;
      data_q      <= 8'h00;
    end else begin
      tag_q       <= tag_d;
      tag_valid_q <= tag_valid_d;
      data_q      <= data_d;
    end
  end

  // The tag records the address a fetch was issued with, so a core address
  // that moved while the fetch was outstanding shows up as pending again.
  assign pending = ~roe_n & (~tag_valid_q | (raw_addr != tag_q));
  assign data    = data_q;

endmodule

// File: rtl/jt10_adpcm_rom.sv
// YM2610 ADPCM ROM responder.
// Turns the ADPCM-A / ADPCM-B address and output-enable lines into byte
// fetches from one shared memory via a level req / pulse ack handshake.
// Ports:
//   rst, clk                         - synchronous active-high reset, clock
//   adpcma_addr/bank/roe_n -> data   - ADPCM-A channel
//   adpcmb_addr/roe_n      -> data   - ADPCM-B channel
//   mem_addr, mem_req                - external request (held until ack)
//   mem_ack, mem_data                - one-cycle ack with read data
module jt10_adpcm_rom
  import jt10_adpcm_rom_pkg::*;
#(
  parameter logic [24:0] ADPCMA_OFFSET = ADPCMA_OFFSET_DEF,
  parameter logic [24:0] ADPCMB_OFFSET = ADPCMB_OFFSET_DEF
) (
  input  logic        rst,
  input  logic        clk,
  input  logic [19:0] adpcma_addr,
  input  logic [3:0]  adpcma_bank,
  input  logic        adpcma_roe_n,
  output logic [7:0]  adpcma_data,
  input  logic [23:0] adpcmb_addr,
  input  logic        adpcmb_roe_n,
  output logic [7:0]  adpcmb_data,
  output logic [24:0] mem_addr,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic [7:0]  mem_data
);

  state_t      state_q, state_d;
  logic [23:0] cur_addr_q, cur_addr_d;
  logic        cur_ch_q, cur_ch_d;
  logic        last_q, last_d;
  logic [24:0] mem_addr_q, mem_addr_d;
  logic        mem_req_q, mem_req_d;

  logic [23:0] raw_a;
  logic        pend_a, pend_b;
  logic        pick;
  logic        wr_a, wr_b;

  assign raw_a = {adpcma_bank, adpcma_addr};

  // Acks only count while a fetch is outstanding; stray acks in IDLE fall
  // through without touching either channel.
  assign wr_a = (state_q == ST_WAIT) && mem_ack && (cur_ch_q == CH_A);
  assign wr_b = (state_q == ST_WAIT) && mem_ack && (cur_ch_q == CH_B);

  jt10_adpcm_rom_ch u_ch_a (
    .clk      (clk),
    .rst      (rst),
    .raw_addr (raw_a),
    .roe_n    (adpcma_roe_n),
    .wr_en    (wr_a),
    .wr_tag   (cur_addr_q),
    .wr_data  (mem_data),
    .pending  (pend_a),
    .data     (adpcma_data)
  );

  jt10_adpcm_rom_ch u_ch_b (
    .clk      (clk),
    .rst      (rst),
    .raw_addr (adpcmb_addr),
    .roe_n    (adpcmb_roe_n),
    .wr_en    (wr_b),
    .wr_tag   (cur_addr_q),
    .wr_data  (mem_data),
    .pending  (pend_b),
    .data     (adpcmb_data)
  );

  always_comb begin
    // On a tie the channel not served last wins.
    if (pend_a && pend_b) pick = ~last_q;
    else if (pend_b)      pick = CH_B;
    else                  pick = CH_A;

    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    cur_ch_d   = cur_ch_q;
    last_d     = last_q;
    mem_addr_d = mem_addr_q;
    mem_req_d  = mem_req_q;

    case (state_q)
      ST_IDLE: begin
        mem_req_d = 1'b0;
        if (pend_a || pend_b) begin
          state_d   = ST_WAIT;
          mem_req_d = 1'b1;
          cur_ch_d  = pick;
          if (pick == CH_B) begin
            cur_addr_d = adpcmb_addr;
            mem_addr_d = full_addr(adpcmb_addr, ADPCMB_OFFSET);
          end else begin
            cur_addr_d = raw_a;
            mem_addr_d = full_addr(raw_a, ADPCMA_OFFSET);
          end
        end
      end
      ST_WAIT: begin
        if (mem_ack) begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
          last_d    = cur_ch_q;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cur_addr_q <= 24'h0;
      cur_ch_q   <= CH_A;
      last_q     <= CH_B;
      mem_addr_q <= 25'h0;
      mem_req_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      cur_ch_q   <= cur_ch_d;
      last_q     <= last_d;
      mem_addr_q <= mem_addr_d;
      mem_req_q  <= mem_req_d;
    end
  end

  assign mem_addr = mem_addr_q;
  assign mem_req  = mem_req_q;

endmodule
